// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO with a valid/ready write port.
// Frames are sent back-to-back with no idle gap while the FIFO holds data.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ     = 27000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk_27mhz,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
    localparam int unsigned TimerW     = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW       = PtrW + 1;

    localparam logic [TimerW-1:0] TimerLast = TimerW'(ClksPerBit - 1);
    localparam logic [CntW-1:0]   FullCount = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e state_q, state_d;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [TimerW-1:0] timer_q;
    logic [2:0]        index_q;
    logic [7:0]        shift_q;
    logic              uart_tx_q;

    logic push;
    logic pop;
    logic timer_done;
    logic fifo_empty;
    logic line_bit;

    assign timer_done = (timer_q == TimerLast);
    assign fifo_empty = (count_q == '0);
    assign tx_ready   = (count_q != FullCount);
    assign push       = tx_valid & tx_ready;
    assign fifo_count = count_q;
    assign uart_tx    = uart_tx_q;
    assign busy       = (state_q != StIdle) | ~fifo_empty;

    // FSM state register
    always_ff @(posedge clk_27mhz or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) state_d = StStart;
            end
            StStart: begin
                if (timer_done) state_d = StData;
            end
            StData: begin
                if (timer_done && (index_q == 3'd7)) state_d = StStop;
            end
            StStop: begin
                if (timer_done) state_d = fifo_empty ? StIdle : StStart;
            end
        endcase
    end

    // FSM outputs: line level for the next register stage and FIFO pop strobe
    always_comb begin
        line_bit = 1'b1;
        pop      = 1'b0;
        unique case (state_q)
            StIdle:  pop      = ~fifo_empty;
            StStart: line_bit = 1'b0;
            StData:  line_bit = shift_q[0];
            StStop:  pop      = timer_done & ~fifo_empty;
        endcase
    end

    // Storage has no reset; entries are only read after being written.
    always_ff @(posedge clk_27mhz) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk_27mhz or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            index_q   <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
        end else begin
            uart_tx_q <= line_bit;

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if ((state_q == StIdle) || timer_done) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end

            if (state_q != StData) begin
                index_q <= '0;
            end else if (timer_done) begin
                index_q <= index_q + 1'b1;
            end

            if (pop) begin
                shift_q <= mem[rd_ptr_q];
            end else if ((state_q == StData) && timer_done) begin
                shift_q <= {1'b0, shift_q[7:1]};
            end
        end
    end

endmodule
